// File: rtl/bomb_sequencer.sv
// bomb_sequencer: per-slot bomb fuse/blast timing and
// round-robin sharing of the single flame sprite renderer.
module bomb_sequencer #(
  parameter int NSLOTS      = 4,
  parameter int FUSE_FRAMES = 120,
  parameter int STEP_FRAMES = 6,
  parameter int NSPRITES    = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_tick,
  input  logic              drop_req,
  input  logic [9:0]        drop_x,
  input  logic [9:0]        drop_y,
  output logic              drop_ack,
  output logic              drop_nack,
  output logic [NSLOTS-1:0] slot_busy,
  output logic              explode_pulse,
  output logic [2:0]        explode_slot,
  output logic              flame_valid,
  output logic [9:0]        flame_centerX,
  output logic [9:0]        flame_centerY,
  output logic [2:0]        sprite_num
);

  localparam int IW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

  typedef enum logic [1:0] {IDLE, FUSE, BLAST} slot_st_t;

  slot_st_t   st     [NSLOTS];
  slot_st_t   st_n   [NSLOTS];
  logic [9:0] x      [NSLOTS];
  logic [9:0] x_n    [NSLOTS];
  logic [9:0] y      [NSLOTS];
  logic [9:0] y_n    [NSLOTS];
  logic [7:0] fuse   [NSLOTS];
  logic [7:0] fuse_n [NSLOTS];
  logic [3:0] step   [NSLOTS];
  logic [3:0] step_n [NSLOTS];
  logic [2:0] img    [NSLOTS];
  logic [2:0] img_n  [NSLOTS];

  logic          drop_eval;
  logic          dup;
  logic          has_free;
  logic          load;
  logic          boom;
  logic          found;
  logic [IW-1:0] free_idx;
  logic [IW-1:0] boom_idx;
  logic [IW-1:0] pick;
  logic [IW-1:0] rr;
  logic [IW-1:0] idx;

  always_comb begin
    for (int i = 0; i < NSLOTS; i++)
      slot_busy[i] = (st[i] != IDLE);
  end

  // A request is only evaluated when no response went out last cycle.
  always_comb begin
    drop_eval = drop_req & ~drop_ack & ~drop_nack;
    dup       = 1'b0;
    has_free  = 1'b0;
    free_idx  = '0;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      if (st[i] == IDLE) begin
        has_free = 1'b1;
        free_idx = IW'(i);
      end
    end
    for (int i = 0; i < NSLOTS; i++) begin
      if (st[i] != IDLE && x[i] == drop_x && y[i] == drop_y)
        dup = 1'b1;
    end
    load = drop_eval & ~dup & has_free;
  end

  always_comb begin
    boom     = 1'b0;
    boom_idx = '0;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      st_n[i]   = st[i];
      x_n[i]    = x[i];
      y_n[i]    = y[i];
      fuse_n[i] = fuse[i];
      step_n[i] = step[i];
      img_n[i]  = img[i];
      if (frame_tick) begin
        unique case (st[i])
          FUSE: begin
            fuse_n[i] = fuse[i] - 8'd1;
            if (fuse[i] == 8'd1) begin
              st_n[i]   = BLAST;
              img_n[i]  = '0;
              step_n[i] = 4'(STEP_FRAMES);
              boom      = 1'b1;
              boom_idx  = IW'(i);
            end
          end
          BLAST: begin
            step_n[i] = step[i] - 4'd1;
            if (step[i] == 4'd1) begin
              if (img[i] == 3'(NSPRITES - 1)) begin
                st_n[i] = IDLE;
              end else begin
                img_n[i]  = img[i] + 3'd1;
                step_n[i] = 4'(STEP_FRAMES);
              end
            end
          end
          default: ;
        endcase
      end
      // The loaded slot was IDLE, so the tick never touched it.
      if (load && free_idx == IW'(i)) begin
        st_n[i]   = FUSE;
        x_n[i]    = drop_x;
        y_n[i]    = drop_y;
        fuse_n[i] = 8'(FUSE_FRAMES);
      end
    end
  end

  always_comb begin
    found = 1'b0;
    pick  = rr;
    idx   = '0;
    for (int j = 1; j <= NSLOTS; j++) begin
      idx = IW'((int'(rr) + j) % NSLOTS);
      if (!found && st_n[idx] == BLAST) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NSLOTS; i++) begin
        st[i]   <= IDLE;
        x[i]    <= '0;
        y[i]    <= '0;
        fuse[i] <= '0;
        step[i] <= '0;
        img[i]  <= '0;
      end
      rr            <= IW'(NSLOTS - 1);
      drop_ack      <= 1'b0;
      drop_nack     <= 1'b0;
      explode_pulse <= 1'b0;
      explode_slot  <= '0;
      flame_valid   <= 1'b0;
      flame_centerX <= '0;
      flame_centerY <= '0;
      sprite_num    <= '0;
    end else begin
      for (int i = 0; i < NSLOTS; i++) begin
        st[i]   <= st_n[i];
        x[i]    <= x_n[i];
        y[i]    <= y_n[i];
        fuse[i] <= fuse_n[i];
        step[i] <= step_n[i];
        img[i]  <= img_n[i];
      end
      drop_ack      <= load;
      drop_nack     <= drop_eval & dup;
      explode_pulse <= boom;
      explode_slot  <= 3'(boom_idx);
      if (frame_tick) begin
        flame_valid <= found;
        if (found) begin
          flame_centerX <= x_n[pick];
          flame_centerY <= y_n[pick];
          sprite_num    <= img_n[pick];
          rr            <= pick;
        end
      end
    end
  end

endmodule

// File: tb/tb_bomb_sequencer.sv
// tb_bomb_sequencer: random drops and ticks checked against an
// elapsed-tick model through response queues.
module tb_bomb_sequencer;

  localparam int F  = 3;
  localparam int S  = 2;
  localparam int N  = 5;
  localparam int NS = 4;
  localparam int TP = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          frame_tick;
  logic          drop_req;
  logic [9:0]    drop_x;
  logic [9:0]    drop_y;
  logic          drop_ack;
  logic          drop_nack;
  logic [NS-1:0] slot_busy;
  logic          explode_pulse;
  logic [2:0]    explode_slot;
  logic          flame_valid;
  logic [9:0]    flame_centerX;
  logic [9:0]    flame_centerY;
  logic [2:0]    sprite_num;

  bomb_sequencer #(
    .NSLOTS(NS), .FUSE_FRAMES(F),
    .STEP_FRAMES(S), .NSPRITES(N)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .frame_tick(frame_tick),
    .drop_req(drop_req),
    .drop_x(drop_x), .drop_y(drop_y),
    .drop_ack(drop_ack), .drop_nack(drop_nack),
    .slot_busy(slot_busy),
    .explode_pulse(explode_pulse),
    .explode_slot(explode_slot),
    .flame_valid(flame_valid),
    .flame_centerX(flame_centerX),
    .flame_centerY(flame_centerY),
    .sprite_num(sprite_num)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          nack;
    logic [NS-1:0] mask;
  } dexp_t;

  typedef struct packed {
    logic       v;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] img;
  } fexp_t;

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  task automatic fail_msg(input string nm,
                          input logic [31:0] act,
                          input logic [31:0] exp);
    total++;
    $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  dexp_t dq[$];
  int    eq[$];
  fexp_t fq[$];

  // Model: each bomb is just its position and ticks elapsed.
  bit         m_act [NS];
  logic [9:0] m_x   [NS];
  logic [9:0] m_y   [NS];
  int         m_t   [NS];
  int         m_rr = NS - 1;
  bit         m_prev;
  fexp_t      m_last;
  bit         r_resp, r_nack;
  int         r_ld, r_boom, r_pick, r_k;
  logic [NS-1:0] r_mask;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NS; i++) m_act[i] = 0;
      m_rr = NS - 1;
      m_prev = 0;
      m_last = '0;
      dq.delete();
      eq.delete();
      fq.delete();
    end else begin
      r_resp = 0;
      r_nack = 0;
      r_ld = -1;
      r_boom = -1;
      if (drop_req && !m_prev) begin
        for (int i = 0; i < NS; i++)
          if (m_act[i] && m_x[i] == drop_x && m_y[i] == drop_y)
            r_nack = 1;
        if (r_nack) r_resp = 1;
        else
          for (int i = NS - 1; i >= 0; i--)
            if (!m_act[i]) r_ld = i;
        if (r_ld >= 0) begin
          m_act[r_ld] = 1;
          m_x[r_ld] = drop_x;
          m_y[r_ld] = drop_y;
          m_t[r_ld] = 0;
          r_resp = 1;
        end
      end
      if (frame_tick) begin
        for (int i = NS - 1; i >= 0; i--) begin
          if (m_act[i] && i != r_ld) begin
            m_t[i]++;
            if (m_t[i] == F) r_boom = i;
            if (m_t[i] == F + N * S) m_act[i] = 0;
          end
        end
        if (r_boom >= 0) eq.push_back(r_boom);
        r_pick = -1;
        for (int j = NS; j >= 1; j--) begin
          r_k = (m_rr + j) % NS;
          if (m_act[r_k] && m_t[r_k] >= F) r_pick = r_k;
        end
        if (r_pick >= 0) begin
          m_last.v = 1'b1;
          m_last.x = m_x[r_pick];
          m_last.y = m_y[r_pick];
          m_last.img = 3'((m_t[r_pick] - F) / S);
          m_rr = r_pick;
        end else begin
          m_last.v = 1'b0;
        end
        fq.push_back(m_last);
      end
      if (r_resp) begin
        for (int i = 0; i < NS; i++) r_mask[i] = m_act[i];
        dq.push_back({r_nack, r_mask});
      end
      m_prev = r_resp;
    end
  end

  dexp_t de;
  int    ee;
  fexp_t cur;

  always @(negedge clk) begin
    if (!reset_n) begin
      cur = '0;
    end else begin
      if (drop_ack || drop_nack) begin
        if (dq.size() == 0) begin
          fail_msg("drop_unexpected", {drop_ack, drop_nack}, 0);
        end else begin
          de = dq.pop_front();
          chk("drop_resp", {drop_ack, drop_nack},
              {~de.nack, de.nack});
          chk("slot_busy", slot_busy, de.mask);
        end
      end else if (dq.size() != 0) begin
        de = dq.pop_front();
        fail_msg("drop_missing", 0, {~de.nack, de.nack});
      end
      if (explode_pulse) begin
        if (eq.size() == 0) begin
          fail_msg("explode_unexpected", explode_slot, 0);
        end else begin
          ee = eq.pop_front();
          chk("explode_slot", explode_slot, ee);
        end
      end else if (eq.size() != 0) begin
        ee = eq.pop_front();
        fail_msg("explode_missing", 0, 1);
      end
      if (fq.size() != 0) cur = fq.pop_front();
      chk("flame_valid", flame_valid, cur.v);
      chk("flame_x", flame_centerX, cur.x);
      chk("flame_y", flame_centerY, cur.y);
      chk("sprite_num", sprite_num, cur.img);
    end
  end

  int cnt = 0;
  int pend = 0;

  task automatic step();
    @(negedge clk);
    if (drop_req && (drop_ack || drop_nack)) begin
      drop_req = 0;
      pend = 0;
    end else if (drop_req) begin
      pend++;
      if (pend > 400) begin
        fail_msg("drop_timeout", pend, 400);
        drop_req = 0;
        pend = 0;
      end
    end
    cnt++;
    frame_tick = (cnt % TP == 0);
  endtask

  task automatic wait_resp();
    while (drop_req) step();
  endtask

  task automatic issue(input logic [9:0] px,
                       input logic [9:0] py);
    wait_resp();
    drop_x = px;
    drop_y = py;
    drop_req = 1;
    pend = 0;
  endtask

  task automatic run_ticks(input int n);
    int c = 0;
    while (c < n) begin
      step();
      if (frame_tick) c++;
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, slot_busy, 0);
    chk({nm, "_ack"}, {drop_ack, drop_nack}, 0);
    chk({nm, "_pulse"}, explode_pulse, 0);
    chk({nm, "_fvalid"}, flame_valid, 0);
    chk({nm, "_fx"}, flame_centerX, 0);
    chk({nm, "_fy"}, flame_centerY, 0);
    chk({nm, "_spr"}, sprite_num, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0;
    frame_tick = 0;
    drop_req = 0;
    drop_x = 0;
    drop_y = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset_n = 1;

    issue(10'd100, 10'd200);
    wait_resp();
    run_ticks(15);

    issue(10'd10, 10'd10);
    issue(10'd20, 10'd10);
    issue(10'd30, 10'd10);
    issue(10'd40, 10'd10);
    issue(10'd300, 10'd300);
    wait_resp();
    run_ticks(20);

    issue(10'd64, 10'd64);
    issue(10'd64, 10'd64);
    wait_resp();
    run_ticks(15);

    do step(); while (!frame_tick);
    issue(10'd500, 10'd10);
    wait_resp();
    run_ticks(15);

    issue(10'd1, 10'd1);
    wait_resp();
    run_ticks(4);
    #2;
    reset_n = 0;
    frame_tick = 0;
    drop_req = 0;
    #1;
    chk_zero("async_reset");
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1;
    run_ticks(8);

    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 6)) step();
      if (!drop_req) begin
        drop_x = 10'($urandom_range(0, 4) * 60);
        drop_y = 10'($urandom_range(0, 2) * 90);
        drop_req = 1;
        pend = 0;
      end
    end
    wait_resp();
    run_ticks(20);
    repeat (3) step();
    chk("drop_queue_empty", dq.size(), 0);
    chk("explode_queue_empty", eq.size(), 0);
    chk("busy_final", slot_busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
